// File: rtl/acc_control_unit_if.sv
// Memory bus and accumulator register control bundle
// for the accumulator-machine sequencer.
interface acc_control_unit_if #(
  parameter int N = 8,
  parameter int A = 4
);
  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_rdata;
  logic [N-1:0] mem_wdata;
  logic         mem_we;
  logic [N-1:0] acc_q;
  logic [1:0]   alu_op;
  logic [N-1:0] alu_b;
  logic         acc_reset_n;
  logic         acc_set_n;
  logic         acc_do_nothing;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output alu_op,
    output alu_b,
    output acc_reset_n,
    output acc_set_n,
    output acc_do_nothing,
    input  mem_rdata,
    input  acc_q
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  alu_op,
    input  alu_b,
    input  acc_reset_n,
    input  acc_set_n,
    input  acc_do_nothing,
    output mem_rdata,
    output acc_q
  );
endinterface

// File: rtl/acc_control_unit.sv
// Fetch/decode sequencer driving the accumulator register
// strobes, ALU select and the shared synchronous memory.
module acc_control_unit #(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clock,
  input  logic         reset,
  acc_control_unit_if.master bus,
  output logic [A-1:0] pc,
  output logic         halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_OPERAND,
    S_OPERAND_WAIT,
    S_WRITEBACK,
    S_STORE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_CLR   = 4'h6;
  localparam logic [3:0] OP_SET   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t       state;
  state_t       state_n;
  logic [3:0]   ir_op;
  logic [A-1:0] ir_arg;
  logic [A-1:0] pc_q;
  logic [N-1:0] alu_b_q;
  logic [1:0]   alu_op_q;
  logic         acc_zero;

  assign acc_zero = (bus.acc_q == '0);

  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:        state_n = S_FETCH_WAIT;
      S_FETCH_WAIT:   state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (ir_op == OP_LOAD),
          (ir_op == OP_ADD),
          (ir_op == OP_SUB),
          (ir_op == OP_AND):   state_n = S_OPERAND;
          (ir_op == OP_STORE): state_n = S_STORE;
          (ir_op == OP_CLR),
          (ir_op == OP_SET):   state_n = S_WRITEBACK;
          (ir_op == OP_HALT):  state_n = S_HALT;
          default:             state_n = S_FETCH;
        endcase
      end
      S_OPERAND:      state_n = S_OPERAND_WAIT;
      S_OPERAND_WAIT: state_n = S_WRITEBACK;
      S_WRITEBACK:    state_n = S_FETCH;
      S_STORE:        state_n = S_FETCH;
      S_HALT:         state_n = S_HALT;
      default:        state_n = S_FETCH;
    endcase
  end

  // Only the opcode and address fields of the fetched word are kept
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      ir_op    <= '0;
      ir_arg   <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 2'b00;
    end else begin
      unique case (state)
        S_FETCH_WAIT: begin
          ir_op  <= bus.mem_rdata[N-1:N-4];
          ir_arg <= bus.mem_rdata[A-1:0];
          pc_q   <= pc_q + A'(1);
        end
        S_DECODE: begin
          unique case (1'b1)
            (ir_op == OP_LOAD): alu_op_q <= 2'b00;
            (ir_op == OP_ADD):  alu_op_q <= 2'b01;
            (ir_op == OP_SUB):  alu_op_q <= 2'b10;
            (ir_op == OP_AND):  alu_op_q <= 2'b11;
            (ir_op == OP_JMP):  pc_q <= ir_arg;
            (ir_op == OP_JZ):   if (acc_zero) pc_q <= ir_arg;
            default: ;
          endcase
        end
        S_OPERAND_WAIT: alu_b_q <= bus.mem_rdata;
        default: ;
      endcase
    end
  end

  // Reset masks every strobe and the write enable immediately
  always_comb begin
    bus.mem_addr       = pc_q;
    bus.mem_we         = 1'b0;
    bus.acc_reset_n    = 1'b1;
    bus.acc_set_n      = 1'b1;
    bus.acc_do_nothing = 1'b1;
    unique case (state)
      S_OPERAND: bus.mem_addr = ir_arg;
      S_STORE: begin
        bus.mem_addr = ir_arg;
        bus.mem_we   = !reset;
      end
      S_WRITEBACK: begin
        if (!reset) begin
          unique case (1'b1)
            (ir_op == OP_CLR): bus.acc_reset_n    = 1'b0;
            (ir_op == OP_SET): bus.acc_set_n      = 1'b0;
            default:           bus.acc_do_nothing = 1'b0;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_wdata = bus.acc_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_b     = alu_b_q;
  assign pc            = pc_q;
  assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_acc_control_unit.sv
// Directed bench: memory, accumulator register and ALU
// models around acc_control_unit.
module tb_acc_control_unit;
  localparam int N = 8;
  localparam int A = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [A-1:0] pc;
  logic         halted;

  acc_control_unit_if #(.N(N), .A(A)) bus ();

  acc_control_unit #(.N(N), .A(A)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .pc    (pc),
    .halted(halted)
  );

  always #5 clock = ~clock;

  logic [N-1:0] prog [16];
  logic [N-1:0] rdata = '0;
  logic [N-1:0] acc = '0;
  logic         acc_ld = 1'b0;
  logic [N-1:0] acc_ld_val = '0;
  logic [N-1:0] alu_res;

  always @(posedge clock) rdata <= prog[bus.mem_addr];
  assign bus.mem_rdata = rdata;
  assign bus.acc_q     = acc;

  always_comb begin
    alu_res = bus.alu_b;
    case (bus.alu_op)
      2'b00: alu_res = bus.alu_b;
      2'b01: alu_res = acc + bus.alu_b;
      2'b10: alu_res = acc - bus.alu_b;
      default: alu_res = acc & bus.alu_b;
    endcase
  end

  always @(posedge clock) begin
    if (acc_ld)                   acc <= acc_ld_val;
    else if (!bus.acc_reset_n)    acc <= '0;
    else if (!bus.acc_set_n)      acc <= '1;
    else if (!bus.acc_do_nothing) acc <= alu_res;
  end

  int we_cnt, clr_cnt, set_cnt, dn_cnt;
  logic [A-1:0] st_addr;
  logic [N-1:0] st_data;

  always @(negedge clock) begin
    if (reset) begin
      we_cnt  <= 0;
      clr_cnt <= 0;
      set_cnt <= 0;
      dn_cnt  <= 0;
      st_addr <= '0;
      st_data <= '0;
    end else begin
      if (bus.mem_we) begin
        we_cnt  <= we_cnt + 1;
        st_addr <= bus.mem_addr;
        st_data <= bus.mem_wdata;
      end
      if (!bus.acc_reset_n)    clr_cnt <= clr_cnt + 1;
      if (!bus.acc_set_n)      set_cnt <= set_cnt + 1;
      if (!bus.acc_do_nothing) dn_cnt  <= dn_cnt + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_prog;
    for (int i = 0; i < 16; i++) prog[i] = '0;
  endtask

  task automatic start(input logic [N-1:0] a0);
    reset = 1'b1;
    acc_ld = 1'b1;
    acc_ld_val = a0;
    step(2);
    acc_ld = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_prog();
    start(8'h00);
    checks++;
    if (pc !== 4'h0) begin
      errors++; $display("FAIL reset_pc: got %h expected 0", pc);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL reset_halted: got %b expected 0", halted);
    end
    checks++;
    if (bus.alu_op !== 2'b00 || bus.alu_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_alu: got op=%b b=%h expected op=00 b=00",
               bus.alu_op, bus.alu_b);
    end
    checks++;
    if ({bus.mem_we, bus.acc_reset_n, bus.acc_set_n, bus.acc_do_nothing}
        !== 4'b0111) begin
      errors++;
      $display("FAIL reset_strobes: got we/rn/sn/dn=%b%b%b%b expected 0111",
               bus.mem_we, bus.acc_reset_n, bus.acc_set_n, bus.acc_do_nothing);
    end
    checks++;
    if (bus.mem_addr !== 4'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr);
    end
  endtask

  task automatic test_program;
    clear_prog();
    prog[0] = 8'h1A; prog[1] = 8'h3B; prog[2] = 8'h2C; prog[3] = 8'hF0;
    prog[10] = 8'h05; prog[11] = 8'h03;
    start(8'h77);
    step(6);
    checks++;
    if (acc !== 8'h05) begin
      errors++; $display("FAIL prog_load: got acc=%h expected 05", acc);
    end
    step(6);
    checks++;
    if (acc !== 8'h08 || bus.alu_op !== 2'b01) begin
      errors++;
      $display("FAIL prog_add: got acc=%h op=%b expected acc=08 op=01",
               acc, bus.alu_op);
    end
    step(4);
    checks++;
    if (we_cnt !== 1 || st_addr !== 4'hC || st_data !== 8'h08) begin
      errors++;
      $display("FAIL prog_store: got cnt=%0d addr=%h data=%h expected 1 c 08",
               we_cnt, st_addr, st_data);
    end
    step(2);
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL prog_early_halt: got %b expected 0", halted);
    end
    step(1);
    checks++;
    if (halted !== 1'b1 || pc !== 4'h4) begin
      errors++;
      $display("FAIL prog_halt: got halted=%b pc=%h expected 1 4", halted, pc);
    end
    step(5);
    checks++;
    if (halted !== 1'b1 || pc !== 4'h4 || bus.mem_addr !== 4'h4 ||
        we_cnt !== 1 || dn_cnt !== 2) begin
      errors++;
      $display("FAIL prog_stay: got h=%b pc=%h a=%h we=%0d dn=%0d expected 1 4 4 1 2",
               halted, pc, bus.mem_addr, we_cnt, dn_cnt);
    end
  endtask

  task automatic test_clr_jz;
    clear_prog();
    prog[0] = 8'h60; prog[1] = 8'h95;
    start(8'h5A);
    step(4);
    checks++;
    if (acc !== 8'h00 || clr_cnt !== 1 || set_cnt !== 0) begin
      errors++;
      $display("FAIL clr: got acc=%h clr=%0d set=%0d expected 00 1 0",
               acc, clr_cnt, set_cnt);
    end
    step(3);
    checks++;
    if (pc !== 4'h5) begin
      errors++; $display("FAIL jz_taken: got pc=%h expected 5", pc);
    end
  endtask

  task automatic test_set_jz;
    clear_prog();
    prog[0] = 8'h70; prog[1] = 8'h95;
    start(8'h00);
    step(4);
    checks++;
    if (acc !== 8'hFF || set_cnt !== 1 || clr_cnt !== 0) begin
      errors++;
      $display("FAIL set: got acc=%h set=%0d clr=%0d expected ff 1 0",
               acc, set_cnt, clr_cnt);
    end
    step(3);
    checks++;
    if (pc !== 4'h2) begin
      errors++; $display("FAIL jz_not_taken: got pc=%h expected 2", pc);
    end
  endtask

  task automatic test_jmp_wrap;
    clear_prog();
    prog[0] = 8'h8F;
    start(8'h00);
    step(3);
    checks++;
    if (pc !== 4'hF) begin
      errors++; $display("FAIL jmp: got pc=%h expected f", pc);
    end
    step(2);
    checks++;
    if (pc !== 4'h0 || clr_cnt + set_cnt + dn_cnt + we_cnt !== 0) begin
      errors++;
      $display("FAIL jmp_wrap: got pc=%h strobes=%0d expected 0 0",
               pc, clr_cnt + set_cnt + dn_cnt + we_cnt);
    end
  endtask

  task automatic test_reset_writeback;
    clear_prog();
    prog[0] = 8'h3B; prog[11] = 8'h03;
    start(8'h10);
    step(5);
    checks++;
    if (bus.acc_do_nothing !== 1'b0) begin
      errors++; $display("FAIL wb_active: got dn=%b expected 0", bus.acc_do_nothing);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.acc_do_nothing !== 1'b1) begin
      errors++; $display("FAIL wb_masked: got dn=%b expected 1", bus.acc_do_nothing);
    end
    step(1);
    reset = 1'b0;
    checks++;
    if (acc !== 8'h10) begin
      errors++; $display("FAIL wb_acc_kept: got acc=%h expected 10", acc);
    end
    checks++;
    if (pc !== 4'h0 || bus.alu_op !== 2'b00 || bus.alu_b !== 8'h00 ||
        bus.mem_addr !== 4'h0) begin
      errors++;
      $display("FAIL wb_reset_regs: got pc=%h op=%b b=%h a=%h expected 0 00 00 0",
               pc, bus.alu_op, bus.alu_b, bus.mem_addr);
    end
    step(2);
    checks++;
    if (pc !== 4'h1) begin
      errors++; $display("FAIL wb_refetch: got pc=%h expected 1", pc);
    end
  endtask

  task automatic test_illegal;
    clear_prog();
    prog[0] = 8'hB0;
    start(8'h33);
    step(3);
    checks++;
    if (pc !== 4'h1 || bus.mem_addr !== 4'h1) begin
      errors++;
      $display("FAIL illegal_pc: got pc=%h addr=%h expected 1 1", pc, bus.mem_addr);
    end
    step(2);
    checks++;
    if (pc !== 4'h2 || clr_cnt + set_cnt + dn_cnt + we_cnt !== 0 ||
        acc !== 8'h33) begin
      errors++;
      $display("FAIL illegal_nop: got pc=%h strobes=%0d acc=%h expected 2 0 33",
               pc, clr_cnt + set_cnt + dn_cnt + we_cnt, acc);
    end
  endtask

  task automatic test_back_to_back;
    clear_prog();
    prog[0] = 8'h1A; prog[1] = 8'h4B; prog[2] = 8'h5C;
    prog[10] = 8'h05; prog[11] = 8'h07; prog[12] = 8'hF3;
    start(8'h00);
    step(6);
    checks++;
    if (acc !== 8'h05) begin
      errors++; $display("FAIL b2b_load: got acc=%h expected 05", acc);
    end
    step(6);
    checks++;
    if (acc !== 8'hFE || bus.alu_op !== 2'b10) begin
      errors++;
      $display("FAIL b2b_sub: got acc=%h op=%b expected fe 10", acc, bus.alu_op);
    end
    step(6);
    checks++;
    if (acc !== 8'hF2 || bus.alu_op !== 2'b11 || dn_cnt !== 3) begin
      errors++;
      $display("FAIL b2b_and: got acc=%h op=%b dn=%0d expected f2 11 3",
               acc, bus.alu_op, dn_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_clr_jz();
    test_set_jz();
    test_jmp_wrap();
    test_reset_writeback();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
